// File: rtl/spi_pkg.sv
// Shared types and constants for the slave-side SPI serial engine.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Bit counter width for a frame of w bits; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Parallel-side handshake between the SPI slave shifter and its register block.
interface spi_slave_shifter_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_full;
  logic              rx_read;
  logic              busy;

  modport master (
    output tx_data, tx_load, rx_read,
    input  tx_ready, rx_data, rx_full, busy
  );

  modport slave (
    input  tx_data, tx_load, rx_read,
    output tx_ready, rx_data, rx_full, busy
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus rise/fall detection
// from the synchronised level and one further delay flop.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic PClk,
  input  logic PRESETn,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Shift the pin through the synchroniser chain and the edge-detect flop.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      dly_r  <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_r[SYNC_STAGES-1];
  assign rise = lvl & ~dly_r;
  assign fall = ~lvl & dly_r;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave serial engine: pin synchronisation, mode-dependent edge selection,
// receive deserialiser and one-deep transmit buffer. Optional macro: SPI_SLV_OVERRUN_EN.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic PClk,
  input  logic PRESETn,
  input  logic spi_en,
  input  logic cpol,
  input  logic cpha,
  input  logic lsbfe,
  input  logic sclk_in,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
`ifdef SPI_SLV_OVERRUN_EN
  output logic overrun,
`endif
  spi_slave_shifter_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic ss_lvl_s, ss_rise_s, ss_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic unused_edges_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .PClk(PClk), .PRESETn(PRESETn), .pin(sclk_in),
    .lvl(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .PClk(PClk), .PRESETn(PRESETn), .pin(ss_n),
    .lvl(ss_lvl_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .PClk(PClk), .PRESETn(PRESETn), .pin(mosi),
    .lvl(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_edges_s = ^{sclk_lvl_s, ss_rise_s, mosi_rise_s, mosi_fall_s};

  spi_state_e        state_r, state_nxt_s;
  spi_mode_t         mode_r;
  logic              lsbfe_r, lsbfe_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r, cnt_nxt_s;
  logic              busy_r, miso_oe_r, miso_r;
  logic [DATA_W-1:0] tx_buf_r, tx_sh_r, tx_sh_nxt_s;
  logic              tx_ready_r;
  logic [DATA_W-1:0] rx_sh_r, rx_next_s, rx_data_r;
  logic              rx_full_r;
  logic              active_s, enter_s, exit_s;
  logic              leading_s, trailing_s, sample_s, shift_s;
  logic              load_s, complete_s;

  assign active_s   = (state_r == ACTIVE);
  assign enter_s    = (state_r == IDLE) & ss_fall_s & spi_en;
  assign exit_s     = active_s & (ss_lvl_s | ~spi_en);
  assign leading_s  = mode_r.cpol ? sclk_fall_s : sclk_rise_s;
  assign trailing_s = mode_r.cpol ? sclk_rise_s : sclk_fall_s;
  assign sample_s   = active_s & ~exit_s & (mode_r.cpha ? trailing_s : leading_s);
  assign shift_s    = active_s & ~exit_s & (mode_r.cpha ? leading_s : trailing_s);
  assign complete_s = sample_s & (bit_cnt_r == CNT_LAST);
  // With cpha=0 the only shift edge seen at bit_cnt==0 is the one after a completed frame.
  assign load_s     = (enter_s & ~cpha) | (shift_s & (bit_cnt_r == CNT_ZERO));
  assign rx_next_s  = lsbfe_r ? {mosi_lvl_s, rx_sh_r[DATA_W-1:1]}
                              : {rx_sh_r[DATA_W-2:0], mosi_lvl_s};

  // Next state and bit count for the frame controller.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = bit_cnt_r;
    if (enter_s) begin
      state_nxt_s = ACTIVE;
    end else if (exit_s) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
    if (!active_s || exit_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (sample_s) begin
      cnt_nxt_s = complete_s ? CNT_ZERO : bit_cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = bit_cnt_r;
    end
  end

  // Next transmit shift register contents and bit order.
  always_comb begin
    tx_sh_nxt_s = tx_sh_r;
    lsbfe_nxt_s = lsbfe_r;
    if (load_s) begin
      tx_sh_nxt_s = tx_ready_r ? {DATA_W{1'b0}} : tx_buf_r;
    end else if (shift_s) begin
      tx_sh_nxt_s = lsbfe_r ? {1'b0, tx_sh_r[DATA_W-1:1]} : {tx_sh_r[DATA_W-2:0], 1'b0};
    end else begin
      tx_sh_nxt_s = tx_sh_r;
    end
    if (enter_s) begin
      lsbfe_nxt_s = lsbfe;
    end else begin
      lsbfe_nxt_s = lsbfe_r;
    end
  end

  // Frame controller: state, latched mode, bit counter, busy and pad enable.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      mode_r    <= {1'b0, 1'b0};
      lsbfe_r   <= 1'b0;
      bit_cnt_r <= CNT_ZERO;
      busy_r    <= 1'b0;
      miso_oe_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      lsbfe_r   <= lsbfe_nxt_s;
      bit_cnt_r <= cnt_nxt_s;
      busy_r    <= (state_nxt_s == ACTIVE) && (cnt_nxt_s != CNT_ZERO);
      miso_oe_r <= (state_nxt_s == ACTIVE);
      if (enter_s) begin
        mode_r.cpol <= cpol;
        mode_r.cpha <= cpha;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Transmit side: one-deep buffer, shift register and registered miso.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_buf_r   <= {DATA_W{1'b0}};
      tx_ready_r <= 1'b1;
      tx_sh_r    <= {DATA_W{1'b0}};
      miso_r     <= 1'b0;
    end else begin
      tx_sh_r <= tx_sh_nxt_s;
      miso_r  <= lsbfe_nxt_s ? tx_sh_nxt_s[0] : tx_sh_nxt_s[DATA_W-1];
      if (load_s && !tx_ready_r) begin
        tx_ready_r <= 1'b1;
      end else if (bus.tx_load && tx_ready_r) begin
        tx_buf_r   <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
    end
  end

`ifdef SPI_SLV_OVERRUN_EN
  logic overrun_r;
  logic ovr_set_s;
  // A frame landing on an unread one that is not being read this cycle is dropped.
  assign ovr_set_s = complete_s & rx_full_r & ~bus.rx_read;
`endif

  // Receive side: deserialiser, frame register and full flag.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_sh_r   <= {DATA_W{1'b0}};
      rx_data_r <= {DATA_W{1'b0}};
      rx_full_r <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
      overrun_r <= 1'b0;
`endif
    end else begin
      if (exit_s || enter_s) begin
        rx_sh_r <= {DATA_W{1'b0}};
      end else if (sample_s) begin
        rx_sh_r <= rx_next_s;
      end else begin
        rx_sh_r <= rx_sh_r;
      end
`ifdef SPI_SLV_OVERRUN_EN
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (bus.rx_read) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (complete_s && !ovr_set_s) begin
        rx_data_r <= rx_next_s;
      end else begin
        rx_data_r <= rx_data_r;
      end
`else
      if (complete_s) begin
        rx_data_r <= rx_next_s;
      end else begin
        rx_data_r <= rx_data_r;
      end
`endif
      if (complete_s) begin
        rx_full_r <= 1'b1;
      end else if (bus.rx_read) begin
        rx_full_r <= 1'b0;
      end else begin
        rx_full_r <= rx_full_r;
      end
    end
  end

`ifdef SPI_SLV_OVERRUN_EN
  assign overrun = overrun_r;
`endif

  assign miso         = miso_r;
  assign miso_oe      = miso_oe_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_full  = rx_full_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a bit-banged SPI master with miso and
// rx frame scoreboards. Covers SPI_SLV_OVERRUN_EN when that macro is defined.
module tb_spi_slave_shifter;

  localparam int H = 6;

  logic PClk = 1'b0;
  logic PRESETn, spi_en, cpol, cpha, lsbfe, sclk_in, ss_n, mosi;
  logic miso, miso_oe;
`ifdef SPI_SLV_OVERRUN_EN
  logic overrun;
`endif

  int checks = 0;
  int errors = 0;
  logic       miso_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_a, exp_b;

  spi_slave_shifter_if #(.DATA_W(8)) bus ();

  spi_slave_shifter #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .PClk(PClk), .PRESETn(PRESETn), .spi_en(spi_en),
    .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .sclk_in(sclk_in), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
`ifdef SPI_SLV_OVERRUN_EN
    .overrun(overrun),
`endif
    .bus(bus)
  );

  always #5 PClk = ~PClk;

  task automatic tick(input int n);
    repeat (n) @(negedge PClk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample-edge half period; optionally pulses rx_read in the completion cycle.
  task automatic half(input bit rd);
    if (rd) begin
      tick(2);
      bus.rx_read = 1'b1;
      tick(1);
      bus.rx_read = 1'b0;
      tick(H - 3);
    end else begin
      tick(H);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input logic [7:0] mi_exp, input int nbits, input bit rd);
    int  b;
    logic e;
    for (int i = 0; i < nbits; i++) begin
      b = lsbfe ? i : 7 - i;
      miso_q.push_back(mi_exp[b]);
    end
    if (nbits == 8) rx_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      b = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[b];
        tick(H);
        e = miso_q.pop_front();
        chk("miso_bit", {31'd0, miso}, {31'd0, e});
        sclk_in = ~cpol;
        half(rd && (i == nbits - 1));
        sclk_in = cpol;
        tick(H);
      end else begin
        sclk_in = ~cpol;
        mosi = mo[b];
        tick(H);
        e = miso_q.pop_front();
        chk("miso_bit", {31'd0, miso}, {31'd0, e});
        sclk_in = cpol;
        half(rd && (i == nbits - 1));
      end
    end
  endtask

  task automatic set_mode(input logic cp, input logic ph, input logic lf);
    cpol = cp; cpha = ph; lsbfe = lf; sclk_in = cp;
    tick(8);
  endtask

  task automatic load_tx(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic read_rx();
    bus.rx_read = 1'b1;
    tick(1);
    bus.rx_read = 1'b0;
    tick(1);
    chk("rx_full_clr", {31'd0, bus.rx_full}, 32'd0);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    for (int k = 0; k < 40 && !bus.rx_full; k++) tick(1);
    chk("rx_full_set", {31'd0, bus.rx_full}, 32'd1);
    e = rx_q.pop_front();
    chk(tag, {24'd0, bus.rx_data}, {24'd0, e});
  endtask

  initial begin
    PRESETn = 1'b0; spi_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    sclk_in = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    bus.tx_data = 8'h00; bus.tx_load = 1'b0; bus.rx_read = 1'b0;
    tick(3);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_rx_full", {31'd0, bus.rx_full}, 32'd0);
    chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    PRESETn = 1'b1;
    tick(4);

    // Mode 0, MSB first, A5 preloaded, master sends 3C.
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5);
    tick(1);
    chk("m0_tx_ready_lo", {31'd0, bus.tx_ready}, 32'd0);
    ss_n = 1'b0; tick(8);
    chk("m0_miso_oe", {31'd0, miso_oe}, 32'd1);
    chk("m0_tx_ready_hi", {31'd0, bus.tx_ready}, 32'd1);
    xfer(8'h3C, 8'hA5, 8, 1'b0);
    check_rx("m0_rx_data");
    chk("m0_busy_end", {31'd0, bus.busy}, 32'd0);
    read_rx();
    ss_n = 1'b1; tick(8);
    chk("m0_oe_off", {31'd0, miso_oe}, 32'd0);

    // Mode 3, LSB first, two frames with ss_n held low.
    set_mode(1'b1, 1'b1, 1'b1);
    load_tx(8'h81);
    ss_n = 1'b0; tick(8);
    xfer(8'h5A, 8'h81, 8, 1'b0);
    check_rx("m3_rx1");
    chk("m3_busy_wrap", {31'd0, bus.busy}, 32'd0);
    read_rx();
    load_tx(8'h7E);
    xfer(8'hC3, 8'h7E, 8, 1'b0);
    check_rx("m3_rx2");
    read_rx();
    ss_n = 1'b1; tick(8);

    // Modes 1 and 2 with no tx_load: underrun zeros.
    set_mode(1'b0, 1'b1, 1'b0);
    ss_n = 1'b0; tick(8);
    xfer(8'h96, 8'h00, 8, 1'b0);
    check_rx("m1_rx");
    read_rx();
    ss_n = 1'b1; tick(8);
    set_mode(1'b1, 1'b0, 1'b0);
    ss_n = 1'b0; tick(8);
    xfer(8'h69, 8'h00, 8, 1'b0);
    check_rx("m2_rx");
    read_rx();
    ss_n = 1'b1; tick(8);

    // Partial frame aborted after 5 bits, then a full F0 frame.
    set_mode(1'b0, 1'b0, 1'b0);
    ss_n = 1'b0; tick(8);
    xfer(8'hAA, 8'h00, 5, 1'b0);
    chk("part_busy", {31'd0, bus.busy}, 32'd1);
    ss_n = 1'b1; tick(6);
    chk("part_oe_off", {31'd0, miso_oe}, 32'd0);
    chk("part_busy_off", {31'd0, bus.busy}, 32'd0);
    chk("part_rx_full", {31'd0, bus.rx_full}, 32'd0);
    chk("part_rx_keep", {24'd0, bus.rx_data}, 32'h69);
    tick(4);
    ss_n = 1'b0; tick(8);
    xfer(8'hF0, 8'h00, 8, 1'b0);
    check_rx("f0_rx");

    // rx_read in the completion cycle while a frame is still unread.
    xfer(8'h3A, 8'h00, 8, 1'b1);
    tick(1);
    check_rx("rdcoll_rx");
`ifdef SPI_SLV_OVERRUN_EN
    chk("rdcoll_ovr", {31'd0, overrun}, 32'd0);
`endif
    read_rx();

    // Second frame onto an unread first one.
    xfer(8'h11, 8'h00, 8, 1'b0);
    tick(2);
    chk("ovr_first_full", {31'd0, bus.rx_full}, 32'd1);
    xfer(8'h22, 8'h00, 8, 1'b0);
    tick(2);
    exp_a = rx_q.pop_front();
    exp_b = rx_q.pop_front();
    chk("ovr_full", {31'd0, bus.rx_full}, 32'd1);
`ifdef SPI_SLV_OVERRUN_EN
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_rx_keep", {24'd0, bus.rx_data}, {24'd0, exp_a});
    read_rx();
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
`else
    chk("ovw_rx_new", {24'd0, bus.rx_data}, {24'd0, exp_b});
    read_rx();
`endif
    ss_n = 1'b1; tick(8);

    // Async reset mid-frame in mode 1, then a clean frame.
    set_mode(1'b0, 1'b1, 1'b0);
    ss_n = 1'b0; tick(8);
    xfer(8'hC5, 8'h00, 4, 1'b0);
    PRESETn = 1'b0;
    #1;
    chk("arst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("arst_miso", {31'd0, miso}, 32'd0);
    chk("arst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    ss_n = 1'b1; sclk_in = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    tick(8);
    load_tx(8'h5A);
    ss_n = 1'b0; tick(8);
    xfer(8'h99, 8'h5A, 8, 1'b0);
    check_rx("arst_rx_after");
    read_rx();
    ss_n = 1'b1; tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
SPI slave-side serial engine; the far end of the SPI master clock/baud generator. Synchronises the external sclk, ss_n and mosi pins into the PClk domain and detects sample/shift edges per cpol/cpha. Deserialises mosi into a receive register and serialises a one-deep transmit buffer onto miso. Sits between the SPI pins and the APB register block of the slave-side SPI.

Parameters:
DATA_W, 8, frame width in bits; bit counter is clog2(DATA_W) wide.
SYNC_STAGES, 2, flops per pin synchroniser (minimum 2); one extra flop for edge detect.

Ports:
PClk  input  1  system clock; all logic on its rising edge.
PRESETn  input  1  asynchronous, active-low reset.
spi_en  input  1  block enable; low forces the IDLE state.
cpol  input  1  clock idle level; latched at ss_n assertion.
cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at ss_n assertion.
lsbfe  input  1  1 = LSB first, 0 = MSB first; latched at ss_n assertion.
sclk_in  input  1  serial clock from master (async).
ss_n  input  1  slave select, active low (async).
mosi  input  1  serial data in (async).
miso  output  1  serial data out.
miso_oe  output  1  miso output enable (tri-state control at the pad).
tx_data  input  DATA_W  byte to transmit.
tx_load  input  1  write strobe for tx_data.
tx_ready  output  1  transmit buffer empty.
rx_data  output  DATA_W  last complete received frame.
rx_full  output  1  rx_data holds an unread frame.
rx_read  input  1  single-cycle acknowledge; clears rx_full.
busy  output  1  frame in progress (ss_n asserted and bit_cnt != 0).

Behaviour:
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_full=0, tx_ready=1, busy=0, bit_cnt=0, state=IDLE.
- Synchroniser: sclk_in, ss_n, mosi pass through SYNC_STAGES flops. Edge detect compares the last stage with one further flop. Pin-to-internal-edge latency is SYNC_STAGES+1 PClk. Requirement: sclk high and low phases each >= 4 PClk.
- Leading edge = transition away from cpol; trailing edge = transition back to cpol. Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- States:
  - IDLE: synced ss_n high or spi_en low. miso_oe=0, bit_cnt=0.
  - ACTIVE: entered on synced ss_n falling with spi_en=1. Latches cpol/cpha/lsbfe; miso_oe=1.
- Transmit load point:
  - cpha=0: the shift register is loaded at ACTIVE entry, and at the shift edge following each completed frame.
  - cpha=1: the shift register is loaded at the shift edge where bit_cnt==0.
  - On load: if tx_ready=0, load tx_data buffer and set tx_ready=1. Otherwise load all-zeros (underrun).
- miso is always the current shift-register bit (MSB, or LSB if lsbfe). It advances on every shift edge other than the load edge.
- Sample edge: shift synced mosi into the receive shift register; bit_cnt++. When bit_cnt reaches DATA_W-1 on a sample edge:
  - rx_data <= assembled frame; rx_full=1; bit_cnt wraps to 0.
  - Visible 1 PClk after that edge.
- tx_load while tx_ready=1: capture tx_data, tx_ready=0 next cycle. tx_load while tx_ready=0 is ignored.
- rx_read clears rx_full next cycle. If rx_read and frame completion occur in the same cycle, the new frame wins: rx_full stays 1.
- ss_n deassert mid-frame: go to IDLE next cycle; partial frame discarded; bit_cnt=0; miso_oe=0. rx_data/rx_full and tx buffer unchanged.
- spi_en low at any time: same as ss_n deassert.
- Edges while in IDLE are ignored.
- Async reset mid-frame: all state returns to reset values immediately.

Optional Feature:
SPI_SLV_OVERRUN_EN
- Defined: adds output port overrun (1 bit, reset 0). Set when a frame completes while rx_full=1 and rx_read is not asserted that cycle. rx_data is NOT overwritten (old frame kept). overrun is sticky; cleared by rx_read.
- Undefined: port absent; a new frame silently overwrites rx_data.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, ACTIVE), SPI mode typedef {cpol, cpha}, DATA_W default constant, bit_cnt width function.
- One sub-module, spi_pin_sync: SYNC_STAGES synchroniser plus edge detect for one pin. Instantiated for sclk_in and ss_n (edges plus level) and mosi (level only).

Test Plan:
- Mode 0, MSB first, tx_data=8'hA5 preloaded, master sends 8'h3C → miso bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_full=1; tx_ready=1 after the first load.
- Mode 3, lsbfe=1, two back-to-back frames with ss_n held low, tx buffer 8'h81 then 8'h7E → miso carries each LSB-first; rx_full set twice; bit_cnt wraps correctly.
- No tx_load before frame (modes 1 and 2) → miso all-zeros for 8 bits; frame still received correctly.
- ss_n raised after 5 bits, then new 8'hF0 frame → partial discarded; rx_data=8'hF0 only; miso_oe low between frames.
- rx_read asserted in the same cycle as frame completion → rx_full remains 1. With SPI_SLV_OVERRUN_EN, unread frame then second frame → overrun=1 and rx_data keeps the first frame.
- PRESETn pulsed low mid-frame in mode 1 → all outputs at reset values same cycle; the next full frame is received cleanly.
